// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizing for the FIFO write arbiter
package fifo_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_OWN
    } arb_state_t;

    localparam int ARB_NUM_REQ   = 4;
    localparam int ARB_WIDTH     = 16;
    localparam int ARB_BURST_MAX = 4;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker
//
// Purpose: returns the first asserted request index strictly after last_idx,
// wrapping NUM_REQ-1 -> 0. When last_idx is the only requester it is picked
// again after a full lap.
// Ports:
//   req       in   NUM_REQ  request vector
//   last_idx  in   IDX_W    index of the previous winner
//   next_idx  out  IDX_W    chosen index (last_idx when nothing is requested)
//   valid     out  1        at least one request is asserted
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_idx,
    output logic [IDX_W-1:0]   next_idx,
    output logic               valid
);

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx      = '0;
        next_idx = last_idx;
        valid    = 1'b0;
        // Scan from the farthest candidate to the nearest so the nearest
        // asserted request is the last one written and therefore wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IDX_W'((int'(last_idx) + k) % NUM_REQ);
            if (req[idx]) begin
                next_idx = idx;
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin, burst-bounded arbiter for a FIFO write port
//
// Purpose: shares one FIFO write port among NUM_REQ producers. An idle cycle
// picks the next owner after the previous one; the owner then pushes up to
// BURST_MAX words, stalling (not releasing) while the FIFO is full.
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   req            per-requester word available, held with data until granted
//   req_data       flattened words, requester i at [i*WIDTH +: WIDTH]
//   gnt            one-hot strobe: requester i's word consumed this cycle
//   fifo_full_bar  FIFO has space
//   fifo_put       FIFO put strobe
//   fifo_data_in   FIFO write data (owner's word)
//   owner          current / last owner index
//   busy           an owner holds the port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = ARB_NUM_REQ,
    parameter int WIDTH     = ARB_WIDTH,
    parameter int BURST_MAX = ARB_BURST_MAX,
    parameter int IDX_W     = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]         gnt,
    input  logic                       fifo_full_bar,
    output logic                       fifo_put,
    output logic [WIDTH-1:0]           fifo_data_in,
    output logic [IDX_W-1:0]           owner,
    output logic                       busy
);

    localparam int CNT_W = $clog2(BURST_MAX) + 1;

    arb_state_t        state, state_nxt;
    logic [IDX_W-1:0]  owner_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              accept;
    logic [WIDTH-1:0]  data_arr [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign data_arr[i] = req_data[i*WIDTH +: WIDTH];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req      (req),
        .last_idx (owner),
        .next_idx (pick_idx),
        .valid    (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            // Parking on the last index gives requester 0 first priority.
            owner <= IDX_W'(NUM_REQ - 1);
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    owner_nxt = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = ARB_OWN;
                end
            end
            ARB_OWN: begin
                accept = req[owner] & fifo_full_bar;
                if (!req[owner]) begin
                    state_nxt = ARB_IDLE;
                end else if (fifo_full_bar) begin
                    if (cnt == CNT_W'(BURST_MAX - 1)) begin
                        state_nxt = ARB_IDLE;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
            end
        endcase
    end

    // A word is transferred only when put and gnt are high together, so
    // gnt is derived from the same accept term as fifo_put.
    assign fifo_put     = accept;
    assign gnt          = NUM_REQ'(accept) << owner;
    assign fifo_data_in = data_arr[owner];
    assign busy         = (state == ARB_OWN);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ   = 4;
    localparam int WIDTH     = 16;
    localparam int BURST_MAX = 4;
    localparam int IDX_W     = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic                     fifo_full_bar;
    logic                     fifo_put;
    logic [WIDTH-1:0]         fifo_data_in;
    logic [IDX_W-1:0]         owner;
    logic                     busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .BURST_MAX (BURST_MAX),
        .IDX_W     (IDX_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .fifo_full_bar (fifo_full_bar),
        .fifo_put      (fifo_put),
        .fifo_data_in  (fifo_data_in),
        .owner         (owner),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Producers: each has a number of words left to offer and the word on offer.
    int               remaining [NUM_REQ];
    logic [WIDTH-1:0] cur_data  [NUM_REQ];
    logic [WIDTH-1:0] data_step [NUM_REQ];

    // Reference model: ownership episodes separated by one arbitration cycle.
    bit m_idle;
    int m_owner;
    int m_words;

    int put_count;
    int grant_owner_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_idle  = 1'b1;
        m_owner = NUM_REQ - 1;
        m_words = 0;
    endtask

    // One clock cycle: drive inputs, predict and compare at the falling edge,
    // then let producers consume whatever the DUT granted.
    task automatic step(input bit rst_v, input bit fb);
        logic [NUM_REQ-1:0] rq;
        logic [NUM_REQ-1:0] e_gnt;
        logic [NUM_REQ-1:0] seen_gnt;
        bit                 e_put;
        bit                 found;
        int                 cand;
        for (int i = 0; i < NUM_REQ; i++) begin
            rq[i] = (remaining[i] > 0);
            req_data[i*WIDTH +: WIDTH] = cur_data[i];
        end
        req           = rq;
        reset         = rst_v;
        fifo_full_bar = fb;
        @(negedge clk);
        e_put = 1'b0;
        e_gnt = '0;
        check("busy", busy, {31'd0, !m_idle});
        check("owner", owner, m_owner);
        if (m_idle) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = (m_owner + k) % NUM_REQ;
                if (!found && rq[cand]) begin
                    found   = 1'b1;
                    m_owner = cand;
                end
            end
            if (found) begin
                m_idle  = 1'b0;
                m_words = 0;
            end
        end else if (!rq[m_owner]) begin
            m_idle = 1'b1;
        end else if (fb) begin
            e_put          = 1'b1;
            e_gnt[m_owner] = 1'b1;
            m_words++;
            if (m_words == BURST_MAX) m_idle = 1'b1;
        end
        check("put", fifo_put, e_put);
        check("gnt", gnt, e_gnt);
        if (e_put) check("data", fifo_data_in, cur_data[m_owner]);
        check("onehot", ($countones(gnt) <= 1), 1);
        if (rst_v) model_reset();
        seen_gnt = gnt;
        if (fifo_put) begin
            put_count++;
            grant_owner_q.push_back(int'(owner));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (seen_gnt[i]) begin
                remaining[i]--;
                cur_data[i] = (data_step[i] != 0) ? cur_data[i] + data_step[i] : WIDTH'($urandom);
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NUM_REQ; i++) begin
            remaining[i] = 0;
            data_step[i] = '0;
        end
        req   = '0;
        reset = 1'b1;
        fifo_full_bar = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_put", fifo_put, 0);
        check("rst_busy", busy, 0);
        check("rst_owner", owner, NUM_REQ - 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        put_count = 0;
        grant_owner_q.delete();
    endtask

    initial begin
        reset         = 1'b1;
        req           = '0;
        req_data      = '0;
        fifo_full_bar = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) begin
            remaining[i] = 0;
            cur_data[i]  = WIDTH'($urandom);
            data_step[i] = '0;
        end
        model_reset();

        // Single owner, three words then release
        do_reset();
        cur_data[0]  = 16'h1111;
        data_step[0] = 16'h1111;
        remaining[0] = 3;
        repeat (6) step(1'b0, 1'b1);
        check("single_puts", put_count, 3);
        check("single_busy_end", busy, 0);
        data_step[0] = '0;

        // Full rotation with every requester held
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 1000;
        repeat (20) step(1'b0, 1'b1);
        check("rot_puts", put_count, 16);
        check("rot_q_size", grant_owner_q.size(), 16);
        for (int k = 0; k < 16 && k < grant_owner_q.size(); k++)
            check("rot_order", grant_owner_q[k], k / BURST_MAX);
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
        repeat (2) step(1'b0, 1'b1);

        // Backpressure on owner 2 after two words
        do_reset();
        remaining[2] = 4;
        repeat (3) step(1'b0, 1'b1);
        repeat (3) step(1'b0, 1'b0);
        check("bp_owner_stall", owner, 2);
        repeat (3) step(1'b0, 1'b1);
        check("bp_puts", put_count, 4);
        check("bp_busy_end", busy, 0);

        // Wrap priority
        do_reset();
        remaining[1] = 4;
        repeat (5) step(1'b0, 1'b1);
        grant_owner_q.delete();
        remaining[1] = 4;
        remaining[3] = 4;
        repeat (12) step(1'b0, 1'b1);
        check("wrap_first", (grant_owner_q.size() > 0) ? grant_owner_q[0] : 99, 3);
        check("wrap_second", (grant_owner_q.size() > 4) ? grant_owner_q[4] : 99, 1);
        remaining[3] = 1;
        repeat (3) step(1'b0, 1'b1);
        grant_owner_q.delete();
        remaining[0] = 1;
        repeat (3) step(1'b0, 1'b1);
        check("wrap_to_zero", (grant_owner_q.size() > 0) ? grant_owner_q[0] : 99, 0);

        // Early release by owner 1
        do_reset();
        remaining[1] = 2;
        repeat (4) step(1'b0, 1'b1);
        check("early_puts", put_count, 2);
        check("early_busy", busy, 0);
        grant_owner_q.delete();
        for (int i = 0; i < 3; i++) remaining[i] = 3;
        repeat (2) step(1'b0, 1'b1);
        check("early_next", (grant_owner_q.size() > 0) ? grant_owner_q[0] : 99, 2);
        for (int i = 0; i < NUM_REQ; i++) remaining[i] = 0;
        step(1'b0, 1'b1);

        // Reset in the middle of owner 3's burst
        do_reset();
        remaining[3] = 8;
        repeat (3) step(1'b0, 1'b1);
        remaining[0] = 2;
        remaining[2] = 2;
        step(1'b1, 1'b1);
        grant_owner_q.delete();
        repeat (3) step(1'b0, 1'b1);
        check("rmb_first", (grant_owner_q.size() > 0) ? grant_owner_q[0] : 99, 0);

        // Randomized traffic, backpressure and occasional reset
        do_reset();
        repeat (2000) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (remaining[i] <= 0 && ($urandom % 4) == 0)
                    remaining[i] = $urandom_range(1, 6);
                else if (remaining[i] > 0 && ($urandom % 32) == 0)
                    remaining[i] = 0;
            end
            step(($urandom % 100) == 0, ($urandom % 5) != 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
